// File: rtl/lab4_sys_ring_router_input_unit.sv
// lab4_sys_ring_router_input_unit: buffered ring-router input port that queues net messages and routes the head entry
// Ports: clk/reset (async active-high); router_id static id of this router;
//   istream_msg/val/rdy inbound message handshake;
//   ostream_msg head message, ostream_val one-hot {west,east,terminal}, ostream_rdy per-direction ready;
//   num_entries current queue occupancy.
module lab4_sys_ring_router_input_unit #(
  parameter int p_msg_nbits   = 89,
  parameter int p_num_entries = 2,
  parameter int p_num_routers = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [1:0]                         router_id,
  input  logic [p_msg_nbits-1:0]             istream_msg,
  input  logic                               istream_val,
  output logic                               istream_rdy,
  output logic [p_msg_nbits-1:0]             ostream_msg,
  output logic [2:0]                         ostream_val,
  input  logic [2:0]                         ostream_rdy,
  output logic [$clog2(p_num_entries):0]     num_entries
);
  localparam int c_pw = $clog2(p_num_entries);
  localparam int c_cw = c_pw + 1;
  localparam logic [c_cw-1:0] c_full = c_cw'(p_num_entries);
  localparam logic [1:0] c_half = 2'(p_num_routers / 2);
  logic [p_msg_nbits-1:0] mem_q [p_num_entries];
  logic [c_pw-1:0] head_q, head_d, tail_q, tail_d;
  logic [c_cw-1:0] count_q, count_d;
  logic enq, deq, tie_west;
  logic [1:0] fwd;
  logic [2:0] route;
  // ready drops while full even if the head leaves this cycle: no pipelined ready
  assign istream_rdy = !reset && (count_q < c_full);
  assign enq = istream_val && istream_rdy;
  assign ostream_msg = mem_q[head_q];
  // hop distance around the ring; 2-bit wraparound gives the modulo for free
  assign fwd = ostream_msg[p_msg_nbits-1 -: 2] - router_id;
  // src[0] breaks the half-ring tie
  assign tie_west = ostream_msg[p_msg_nbits-4];
  assign route = fwd == 2'd0 ? 3'b001 :
                 fwd < c_half ? 3'b010 :
                 fwd > c_half ? 3'b100 :
                 tie_west ? 3'b100 : 3'b010;
  assign ostream_val = (count_q != '0) ? route : 3'b000;
  assign deq = |(ostream_val & ostream_rdy);
  assign num_entries = count_q;
  always_comb begin
    head_d = deq ? head_q + c_pw'(1) : head_q;
    tail_d = enq ? tail_q + c_pw'(1) : tail_q;
    count_d = count_q + c_cw'(enq) - c_cw'(deq);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= istream_msg;
  end
endmodule

// File: tb/tb_lab4_sys_ring_router_input_unit.sv
// tb_lab4_sys_ring_router_input_unit: directed route table plus queue-model checks for the ring router input unit
module tb_lab4_sys_ring_router_input_unit;
  localparam int c_w = 89;
  logic clk = 0;
  logic reset = 1;
  logic [1:0] router_id = 0;
  logic [c_w-1:0] istream_msg = '0;
  logic istream_val = 0;
  logic istream_rdy;
  logic [c_w-1:0] ostream_msg;
  logic [2:0] ostream_val;
  logic [2:0] ostream_rdy = 0;
  logic [1:0] num_entries;

  lab4_sys_ring_router_input_unit dut (
    .clk(clk), .reset(reset), .router_id(router_id),
    .istream_msg(istream_msg), .istream_val(istream_val), .istream_rdy(istream_rdy),
    .ostream_msg(ostream_msg), .ostream_val(ostream_val), .ostream_rdy(ostream_rdy),
    .num_entries(num_entries)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [c_w-1:0] q[$];
  logic [1:0] cur_id = 0;
  logic [2:0] seen_val;
  int seen_cnt;
  int delivered = 0;
  bit last_enq;
  int max_size = 0;

  typedef struct {
    logic [1:0] id;
    logic [1:0] dest;
    logic [1:0] src;
    logic [2:0] exp;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [c_w-1:0] mk(input logic [1:0] dest, input logic [1:0] src);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return {dest, src, 8'($urandom), r[76:0]};
  endfunction

  // ring routing by plain modular arithmetic on the header fields
  function automatic logic [2:0] route_ref(input logic [1:0] id, input logic [c_w-1:0] m);
    int d, s, i, f;
    d = int'(m[c_w-1 -: 2]);
    s = int'(m[c_w-3 -: 2]);
    i = int'(id);
    f = (d - i + 4) % 4;
    if (f == 0) return 3'b001;
    if (f < 2) return 3'b010;
    if (f > 2) return 3'b100;
    return (s % 2) ? 3'b100 : 3'b010;
  endfunction

  function automatic logic [2:0] model_val();
    return (q.size() > 0) ? route_ref(cur_id, q[0]) : 3'b000;
  endfunction

  task automatic cycle(input bit rs, input bit v, input logic [c_w-1:0] m, input logic [2:0] r);
    logic [2:0] ev;
    bit er, do_deq, do_enq;
    @(negedge clk);
    reset = rs;
    router_id = cur_id;
    istream_val = v;
    istream_msg = m;
    ostream_rdy = r;
    if (rs) q.delete();
    #1;
    er = !rs && q.size() < 2;
    ev = model_val();
    chk("istream_rdy", istream_rdy, er);
    chk("ostream_val", ostream_val, ev);
    chk("num_entries", num_entries, q.size());
    if (q.size() > 0) chk("ostream_msg", ostream_msg, q[0]);
    seen_val = ostream_val;
    seen_cnt = int'(num_entries);
    do_deq = |(ev & r);
    do_enq = v && er;
    last_enq = do_enq;
    @(posedge clk);
    if (do_deq) begin
      void'(q.pop_front());
      delivered++;
    end
    if (do_enq) q.push_back(m);
    if (q.size() > max_size) max_size = q.size();
  endtask

  initial begin
    logic [c_w-1:0] m, ms[20];
    int sent, cyc;
    tbl[0]  = '{2'd1, 2'd1, 2'd0, 3'b001};
    tbl[1]  = '{2'd1, 2'd2, 2'd0, 3'b010};
    tbl[2]  = '{2'd1, 2'd0, 2'd0, 3'b100};
    tbl[3]  = '{2'd0, 2'd2, 2'd0, 3'b010};
    tbl[4]  = '{2'd0, 2'd2, 2'd3, 3'b100};
    tbl[5]  = '{2'd3, 2'd0, 2'd0, 3'b010};
    tbl[6]  = '{2'd3, 2'd2, 2'd0, 3'b100};
    tbl[7]  = '{2'd2, 2'd2, 2'd1, 3'b001};
    tbl[8]  = '{2'd0, 2'd1, 2'd2, 3'b010};
    tbl[9]  = '{2'd0, 2'd3, 2'd1, 3'b100};
    tbl[10] = '{2'd2, 2'd0, 2'd1, 3'b100};
    tbl[11] = '{2'd2, 2'd0, 2'd2, 3'b010};

    // reset held with a valid input pending
    cur_id = 2'd1;
    cycle(1, 1, mk(2'd1, 2'd0), 3'b000);
    cycle(1, 1, mk(2'd1, 2'd0), 3'b000);
    chk("reset_val", seen_val, 3'b000);
    chk("reset_cnt", seen_cnt, 0);
    m = mk(2'd1, 2'd0);
    cycle(0, 1, m, 3'b000);
    chk("no_bypass", seen_val, 3'b000);
    cycle(0, 0, '0, 3'b000);
    chk("first_visible", seen_val, 3'b001);
    cycle(0, 0, '0, 3'b111);

    // router 1 streams dest 1,2,0 with all readies high
    cycle(0, 1, mk(2'd1, 2'd0), 3'b111);
    cycle(0, 1, mk(2'd2, 2'd0), 3'b111);
    chk("seq_term", seen_val, 3'b001);
    cycle(0, 1, mk(2'd0, 2'd0), 3'b111);
    chk("seq_east", seen_val, 3'b010);
    cycle(0, 0, '0, 3'b111);
    chk("seq_west", seen_val, 3'b100);
    cycle(0, 0, '0, 3'b111);
    chk("seq_empty", seen_cnt, 0);

    // route table, one router id per reset
    foreach (tbl[i]) begin
      cur_id = tbl[i].id;
      cycle(1, 0, '0, 3'b000);
      cycle(0, 1, mk(tbl[i].dest, tbl[i].src), 3'b000);
      cycle(0, 0, '0, ~tbl[i].exp);
      chk($sformatf("tbl_route%0d", i), seen_val, tbl[i].exp);
      cycle(0, 0, '0, tbl[i].exp);
      cycle(0, 0, '0, 3'b000);
      chk($sformatf("tbl_drain%0d", i), seen_cnt, 0);
    end

    // backpressure: third message blocked until a full-cycle dequeue frees a slot
    cur_id = 2'd0;
    cycle(1, 0, '0, 3'b000);
    cycle(0, 1, mk(2'd1, 2'd0), 3'b000);
    cycle(0, 1, mk(2'd3, 2'd1), 3'b000);
    m = mk(2'd0, 2'd2);
    for (int k = 0; k < 10; k++) cycle(0, 1, m, 3'b000);
    chk("bp_full", seen_cnt, 2);
    cycle(0, 1, m, 3'b111);
    chk("bp_full_deq_no_enq", last_enq, 1'b0);
    cycle(0, 1, m, 3'b000);
    chk("bp_third_accepted", last_enq, 1'b1);
    cycle(0, 0, '0, 3'b111);
    cycle(0, 0, '0, 3'b111);
    cycle(0, 0, '0, 3'b111);
    chk("bp_drained", q.size(), 0);

    // streaming with random ready on the routed direction only
    cur_id = 2'($urandom);
    cycle(1, 0, '0, 3'b000);
    foreach (ms[i]) ms[i] = mk(2'($urandom), 2'($urandom));
    delivered = 0;
    max_size = 0;
    sent = 0;
    cyc = 0;
    while (delivered < 20 && cyc < 400) begin
      cycle(0, sent < 20, (sent < 20) ? ms[sent] : '0, model_val() & {3{1'($urandom)}});
      if (last_enq) sent++;
      cyc++;
    end
    chk("stream_delivered", delivered, 20);
    chk("stream_max_le2", max_size <= 2, 1'b1);

    // fully random traffic including occasional mid-run resets
    for (int k = 0; k < 300; k++) begin
      bit rs;
      rs = ($urandom_range(0, 39) == 0);
      if (rs) cur_id = 2'($urandom);
      cycle(rs, 1'($urandom), mk(2'($urandom), 2'($urandom)), 3'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
